// File: rtl/hit_judge.sv
// hit_judge
//
// Queues each spawned arrow pattern together with the timestamp of the cycle it
// was accepted. It judges both players' key presses against the arrow at the
// head of the queue. A hit only counts inside a window centred on the moment
// the arrow reaches the target line.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   game_active           game running; low flushes the queue
//   pattern_in[7:0]       [7:4] player A lane mask, [3:0] player B lane mask
//   pattern_valid         one-cycle push strobe for pattern_in
//   player_a_keys[3:0]    player A keys (synchronised, active-high)
//   player_b_keys[3:0]    player B keys (synchronised, active-high)
//   perfect_hit_a/_b      one-cycle pulse per accepted hit
//   miss_a/_b             one-cycle pulse when the head expires unjudged
//   head_valid            queue non-empty
//   head_pattern[7:0]     pattern at the queue head, 0 when empty
//   overflow              sticky: a push was dropped because the queue was full

module hit_judge #(
    parameter int TRAVEL_CYCLES = 100000000,
    parameter int WINDOW_CYCLES = 5000000,
    parameter int DEPTH         = 8,
    parameter int TS_W          = 28
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       game_active,
    input  logic [7:0] pattern_in,
    input  logic       pattern_valid,
    input  logic [3:0] player_a_keys,
    input  logic [3:0] player_b_keys,
    output logic       perfect_hit_a,
    output logic       perfect_hit_b,
    output logic       miss_a,
    output logic       miss_b,
    output logic       head_valid,
    output logic [7:0] head_pattern,
    output logic       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [TS_W-1:0] WIN_LO     = TS_W'(TRAVEL_CYCLES - WINDOW_CYCLES);
    localparam logic [TS_W-1:0] WIN_HI     = TS_W'(TRAVEL_CYCLES + WINDOW_CYCLES);
    localparam logic [TS_W-1:0] EXPIRE_AGE = TS_W'(TRAVEL_CYCLES + WINDOW_CYCLES + 1);

    logic [TS_W-1:0]  ts;
    logic [7:0]       pat_mem   [DEPTH];
    logic [TS_W-1:0]  stamp_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       keys_a_q;
    logic [3:0]       keys_b_q;
    logic             done_a;
    logic             done_b;

    logic             not_empty;
    logic             full;
    logic [7:0]       head_pat;
    logic [TS_W-1:0]  age;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic             judging;
    logic             in_window;
    logic             key_evt_a;
    logic             key_evt_b;
    logic             done_a_eff;
    logic             done_b_eff;
    logic             hit_a;
    logic             hit_b;
    logic             expire;
    logic             pop;
    logic             push;
    logic             drop;

    // Judgement of the head entry. The age is the modular distance from the
    // head's stamp, so the free-running timestamp may wrap at any time.
    // A player with an empty lane mask is treated as already done.
    // The "!perfect_hit" term is the one-cycle lockout. It guarantees that
    // score_tracker sees a low cycle between two consecutive hits.
    always_comb begin
        not_empty  = (count != '0);
        full       = (count == CNT_W'(DEPTH));
        head_pat   = pat_mem[rd_ptr];
        age        = ts - stamp_mem[rd_ptr];
        nib_a      = head_pat[7:4];
        nib_b      = head_pat[3:0];
        judging    = game_active && not_empty;
        in_window  = (age >= WIN_LO) && (age <= WIN_HI);
        key_evt_a  = (player_a_keys == nib_a) && (keys_a_q != nib_a);
        key_evt_b  = (player_b_keys == nib_b) && (keys_b_q != nib_b);
        done_a_eff = done_a || (nib_a == 4'h0);
        done_b_eff = done_b || (nib_b == 4'h0);
        hit_a      = judging && !done_a_eff && in_window && key_evt_a && !perfect_hit_a;
        hit_b      = judging && !done_b_eff && in_window && key_evt_b && !perfect_hit_b;
        expire     = judging && (age == EXPIRE_AGE);
        pop        = judging && (expire ||
                     ((done_a_eff || hit_a) && (done_b_eff || hit_b)));
        push       = game_active && pattern_valid && (!full || pop);
        drop       = game_active && pattern_valid && full && !pop;
    end

    // Queue storage needs no reset: the count decides which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            pat_mem[wr_ptr]   <= pattern_in;
            stamp_mem[wr_ptr] <= ts;
        end
    end

    // Timestamp, key history, output pulses, and queue control.
    // When the game is inactive the queue is flushed and judging stops.
    // The timestamp keeps running and overflow keeps its value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts            <= '0;
            keys_a_q      <= 4'h0;
            keys_b_q      <= 4'h0;
            perfect_hit_a <= 1'b0;
            perfect_hit_b <= 1'b0;
            miss_a        <= 1'b0;
            miss_b        <= 1'b0;
            overflow      <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            done_a        <= 1'b0;
            done_b        <= 1'b0;
        end else begin
            ts            <= ts + TS_W'(1);
            keys_a_q      <= player_a_keys;
            keys_b_q      <= player_b_keys;
            perfect_hit_a <= hit_a;
            perfect_hit_b <= hit_b;
            miss_a        <= expire && !done_a_eff;
            miss_b        <= expire && !done_b_eff;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (!game_active) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                done_a <= 1'b0;
                done_b <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    done_a <= 1'b0;
                    done_b <= 1'b0;
                end else begin
                    if (hit_a) begin
                        done_a <= 1'b1;
                    end
                    if (hit_b) begin
                        done_b <= 1'b1;
                    end
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    assign head_valid   = not_empty;
    assign head_pattern = not_empty ? head_pat : 8'h00;

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge
//
// Directed bench for hit_judge using a short travel time (20 cycles), a
// window of +/-3 cycles and a 4-entry queue. Edge numbers in the scenarios
// count from the edge that accepts the first push of that scenario (edge 0).

module tb_hit_judge;

    localparam int TRAVEL = 20;
    localparam int WINDOW = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       game_active = 1'b0;
    logic [7:0] pattern_in = 8'h00;
    logic       pattern_valid = 1'b0;
    logic [3:0] player_a_keys = 4'h0;
    logic [3:0] player_b_keys = 4'h0;
    logic       perfect_hit_a;
    logic       perfect_hit_b;
    logic       miss_a;
    logic       miss_b;
    logic       head_valid;
    logic [7:0] head_pattern;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;
    int edge_no = -1;
    logic saw_miss;

    hit_judge #(
        .TRAVEL_CYCLES(TRAVEL),
        .WINDOW_CYCLES(WINDOW),
        .DEPTH(4),
        .TS_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .game_active(game_active),
        .pattern_in(pattern_in),
        .pattern_valid(pattern_valid),
        .player_a_keys(player_a_keys),
        .player_b_keys(player_b_keys),
        .perfect_hit_a(perfect_hit_a),
        .perfect_hit_b(perfect_hit_b),
        .miss_a(miss_a),
        .miss_b(miss_b),
        .head_valid(head_valid),
        .head_pattern(head_pattern),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
        edge_no++;
    endtask

    task automatic run_to(input int n);
        while (edge_no < n) tick();
    endtask

    // Present one pattern for exactly one edge.
    task automatic applyStimulus(input logic [7:0] pat);
        pattern_in    = pat;
        pattern_valid = 1'b1;
        tick();
        pattern_valid = 1'b0;
        pattern_in    = 8'h00;
    endtask

    task automatic new_scenario();
        player_a_keys = 4'h0;
        player_b_keys = 4'h0;
        tick();
        tick();
        edge_no = -1;
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("rst_hit_a", {7'b0, perfect_hit_a}, 8'h00);
        checkOutput("rst_hit_b", {7'b0, perfect_hit_b}, 8'h00);
        checkOutput("rst_miss", {6'b0, miss_a, miss_b}, 8'h00);
        checkOutput("rst_head_valid", {7'b0, head_valid}, 8'h00);
        checkOutput("rst_head_pattern", head_pattern, 8'h00);
        checkOutput("rst_overflow", {7'b0, overflow}, 8'h00);
        reset = 1'b0;
        game_active = 1'b1;

        // 1: both players hit 8'hAA at edge 19
        new_scenario();
        applyStimulus(8'hAA);
        checkOutput("t1_head_valid", {7'b0, head_valid}, 8'h01);
        checkOutput("t1_head_pattern", head_pattern, 8'hAA);
        run_to(18);
        player_a_keys = 4'b1010;
        player_b_keys = 4'b1010;
        tick();
        checkOutput("t1_hit_a", {7'b0, perfect_hit_a}, 8'h01);
        checkOutput("t1_hit_b", {7'b0, perfect_hit_b}, 8'h01);
        checkOutput("t1_empty", {7'b0, head_valid}, 8'h00);
        tick();
        checkOutput("t1_hit_a_pulse", {7'b0, perfect_hit_a}, 8'h00);
        checkOutput("t1_hit_b_pulse", {7'b0, perfect_hit_b}, 8'h00);

        // 2: A's early press is held (no event), B hits at 22, A misses at 24
        new_scenario();
        applyStimulus(8'h11);
        run_to(9);
        player_a_keys = 4'b0001;
        run_to(20);
        checkOutput("t2_held_no_hit", {7'b0, perfect_hit_a}, 8'h00);
        run_to(21);
        player_b_keys = 4'b0001;
        tick();
        checkOutput("t2_hit_b", {7'b0, perfect_hit_b}, 8'h01);
        checkOutput("t2_no_hit_a", {7'b0, perfect_hit_a}, 8'h00);
        run_to(23);
        checkOutput("t2_no_early_miss", {7'b0, miss_a}, 8'h00);
        tick();
        checkOutput("t2_miss_a", {7'b0, miss_a}, 8'h01);
        checkOutput("t2_miss_b", {7'b0, miss_b}, 8'h00);
        checkOutput("t2_popped", {7'b0, head_valid}, 8'h00);

        // 3: extra key pressed -> no hit, both miss at 24
        new_scenario();
        applyStimulus(8'h88);
        run_to(19);
        player_a_keys = 4'b1100;
        tick();
        checkOutput("t3_extra_key", {7'b0, perfect_hit_a}, 8'h00);
        run_to(24);
        checkOutput("t3_miss_both", {6'b0, miss_a, miss_b}, 8'h03);
        checkOutput("t3_popped", {7'b0, head_valid}, 8'h00);

        // 4: five consecutive pushes into a 4-entry queue
        new_scenario();
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        applyStimulus(8'h04);
        checkOutput("t4_not_yet_ovf", {7'b0, overflow}, 8'h00);
        applyStimulus(8'h05);
        checkOutput("t4_overflow", {7'b0, overflow}, 8'h01);
        checkOutput("t4_head_first", head_pattern, 8'h01);
        run_to(24);
        checkOutput("t4_miss_first", {6'b0, miss_a, miss_b}, 8'h01);
        checkOutput("t4_next_head", head_pattern, 8'h02);
        run_to(27);
        checkOutput("t4_drained", {7'b0, head_valid}, 8'h00);
        checkOutput("t4_ovf_sticky", {7'b0, overflow}, 8'h01);

        // 5a: only the head is judged; a press for entry 2 while entry 1 is head is lost
        new_scenario();
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        run_to(19);
        player_a_keys = 4'b0001;
        tick();
        checkOutput("t5a_hit_a", {7'b0, perfect_hit_a}, 8'h01);
        player_a_keys = 4'b0010;
        tick();
        checkOutput("t5a_edge21", {7'b0, perfect_hit_a}, 8'h00);
        player_a_keys = 4'b0000;
        tick();
        player_a_keys = 4'b0010;
        tick();
        checkOutput("t5a_not_head", {7'b0, perfect_hit_a}, 8'h00);
        tick();
        checkOutput("t5a_miss_e1", {6'b0, miss_a, miss_b}, 8'h01);
        checkOutput("t5a_head_e2", head_pattern, 8'h22);
        tick();
        checkOutput("t5a_miss_e2", {6'b0, miss_a, miss_b}, 8'h03);

        // 5b: lockout blocks a hit on the cycle right after a hit
        new_scenario();
        applyStimulus(8'h10);
        applyStimulus(8'h20);
        run_to(19);
        player_a_keys = 4'b0001;
        tick();
        checkOutput("t5b_hit_e1", {7'b0, perfect_hit_a}, 8'h01);
        checkOutput("t5b_head_e2", head_pattern, 8'h20);
        player_a_keys = 4'b0010;
        tick();
        checkOutput("t5b_lockout", {7'b0, perfect_hit_a}, 8'h00);
        player_a_keys = 4'b0000;
        tick();
        player_a_keys = 4'b0010;
        tick();
        checkOutput("t5b_hit_e2", {7'b0, perfect_hit_a}, 8'h01);
        checkOutput("t5b_empty", {7'b0, head_valid}, 8'h00);

        // 6: game_active low flushes, ignores pushes, never misses, keeps overflow
        new_scenario();
        applyStimulus(8'h44);
        run_to(4);
        game_active = 1'b0;
        tick();
        checkOutput("t6_flushed", {7'b0, head_valid}, 8'h00);
        applyStimulus(8'h33);
        checkOutput("t6_push_ignored", {7'b0, head_valid}, 8'h00);
        saw_miss = 1'b0;
        while (edge_no < 30) begin
            tick();
            saw_miss = saw_miss | miss_a | miss_b;
        end
        checkOutput("t6_no_miss", {7'b0, saw_miss}, 8'h00);
        checkOutput("t6_ovf_kept", {7'b0, overflow}, 8'h01);
        game_active = 1'b1;

        // 6b: asynchronous reset in the middle of a hit pulse
        new_scenario();
        applyStimulus(8'h11);
        run_to(18);
        player_a_keys = 4'b0001;
        tick();
        checkOutput("t6b_hit_before", {7'b0, perfect_hit_a}, 8'h01);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6b_rst_hit", {7'b0, perfect_hit_a}, 8'h00);
        checkOutput("t6b_rst_head_valid", {7'b0, head_valid}, 8'h00);
        checkOutput("t6b_rst_head_pattern", head_pattern, 8'h00);
        checkOutput("t6b_rst_overflow", {7'b0, overflow}, 8'h00);
        #2 reset = 1'b0;
        player_a_keys = 4'h0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
